// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / enable generator with shadowed, wrap-aligned
// divisor reloads and a global phase-realignment strobe.
module clk_div_multi #(
  parameter int                NCH      = 3,
  parameter int                CW       = 16,
  parameter logic [NCH*CW-1:0] DIV_INIT = {16'd8, 16'd11520, 16'd360},
  parameter int                SW       = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           div_wr,
  input  logic [SW-1:0]  div_sel,
  input  logic [CW-1:0]  div_val,
  input  logic           sync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] ce_out,
  output logic [NCH-1:0] pend
);

  logic [CW-1:0] cnt     [NCH];
  logic [CW-1:0] div_n   [NCH];
  logic [CW-1:0] shadow  [NCH];

  logic [CW-1:0]  cnt_nxt    [NCH];
  logic [CW-1:0]  div_n_nxt  [NCH];
  logic [CW-1:0]  shadow_nxt [NCH];
  logic [NCH-1:0] pend_nxt;
  logic [NCH-1:0] clk_nxt;
  logic [NCH-1:0] ce_nxt;
  logic [CW-1:0]  wr_val;

  // Divisors below 2 cannot produce a square wave, so they are stored as 2.
  assign wr_val = (div_val < CW'(2)) ? CW'(2) : div_val;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pend_nxt = pend;
    clk_nxt  = '0;
    ce_nxt   = '0;
    for (int i = 0; i < NCH; i++) begin
      logic hit;
      logic wrap;
      hit  = div_wr && (div_sel == SW'(i));
      wrap = (cnt[i] == div_n[i] - CW'(1));

      cnt_nxt[i]    = cnt[i] + CW'(1);
      div_n_nxt[i]  = div_n[i];
      shadow_nxt[i] = hit ? wr_val : shadow[i];

      // A write landing on the wrap or sync cycle takes effect with the new period.
      if (sync || wrap) begin
        cnt_nxt[i]   = '0;
        div_n_nxt[i] = shadow_nxt[i];
        pend_nxt[i]  = 1'b0;
      end else if (hit) begin
        pend_nxt[i]  = 1'b1;
      end

      // Outputs are registered copies of the next-cycle count comparisons.
      ce_nxt[i]  = (cnt_nxt[i] == div_n_nxt[i] - CW'(1));
      clk_nxt[i] = (cnt_nxt[i] >= (div_n_nxt[i] >> 1));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        div_n[i]  <= DIV_INIT[i*CW +: CW];
        shadow[i] <= DIV_INIT[i*CW +: CW];
      end
      pend    <= '0;
      clk_out <= '0;
      ce_out  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= cnt_nxt[i];
        div_n[i]  <= div_n_nxt[i];
        shadow[i] <= shadow_nxt[i];
      end
      pend    <= pend_nxt;
      clk_out <= clk_nxt;
      ce_out  <= ce_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: time-based period model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_clk_div_multi;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int SW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           div_wr;
  logic [SW-1:0]  div_sel;
  logic [CW-1:0]  div_val;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] ce_out;
  logic [NCH-1:0] pend;

  clk_div_multi #(.NCH(NCH), .CW(CW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
    .sync(sync), .clk_out(clk_out), .ce_out(ce_out), .pend(pend)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;

  // Model: each channel is a period length plus the absolute time its current period began.
  int init_div [NCH] = '{360, 11520, 8};
  int per      [NCH];
  int start    [NCH];
  int shadow_m [NCH];
  bit pend_m   [NCH];
  int t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit w, input int sel, input int val, input bit sy);
    int v;
    v = (val < 2) ? 2 : val;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        per[i] = init_div[i]; shadow_m[i] = init_div[i]; pend_m[i] = 0; start[i] = t + 1;
      end else begin
        bit wrap;
        wrap = ((t - start[i]) == per[i] - 1);
        if (w && sel == i) shadow_m[i] = v;
        if (sy || wrap) begin
          start[i] = t + 1; per[i] = shadow_m[i]; pend_m[i] = 0;
        end else if (w && sel == i) begin
          pend_m[i] = 1;
        end
      end
    end
    t++;
  endtask

  task automatic compare_model();
    logic [NCH-1:0] e_ce, e_clk, e_pend;
    for (int i = 0; i < NCH; i++) begin
      int ph;
      ph = t - start[i];
      e_ce[i]   = (ph == per[i] - 1);
      e_clk[i]  = (ph >= per[i] / 2);
      e_pend[i] = pend_m[i];
    end
    check("model_ce",   32'(ce_out),  32'(e_ce));
    check("model_clk",  32'(clk_out), 32'(e_clk));
    check("model_pend", 32'(pend),    32'(e_pend));
  endtask

  // One clock cycle: drive, edge, advance model, compare at the opposite edge.
  task automatic step(input bit r, input bit w, input int sel, input int val, input bit sy);
    rst = r; div_wr = w; div_sel = SW'(sel); div_val = CW'(val); sync = sy;
    @(posedge clk);
    model_update(r, w, sel, val, sy);
    @(negedge clk);
    compare_model();
    if (r || sy) ncyc = 1;
    else ncyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic run_to(input int target);
    while (ncyc < target) idle();
  endtask

  initial begin
    rst = 1'b1; div_wr = 1'b0; div_sel = '0; div_val = '0; sync = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_outs", {pend, ce_out, clk_out}, 32'h0);

    // Default divisors: ch2 = 8, ch0 = 360, ch1 = 11520; ch0 reload to 5 at cnt 100.
    run_to(4);   check("ch2_low4",   32'(clk_out[2]), 32'h0);
    run_to(5);   check("ch2_high5",  32'(clk_out[2]), 32'h1);
    run_to(8);   check("ch2_ce8",    32'(ce_out[2]),  32'h1);
    run_to(101);
    step(0, 1, 0, 5, 0);
    check("ch0_pend_set", 32'(pend[0]), 32'h1);
    run_to(180); check("ch0_low180", 32'(clk_out[0]), 32'h0);
    run_to(181); check("ch0_hi181",  32'(clk_out[0]), 32'h1);
    run_to(360); check("ch0_ce360",  {30'h0, pend[0], ce_out[0]}, 32'h3);
    run_to(361); check("ch0_wrap",   {30'h0, pend[0], clk_out[0]}, 32'h0);
    run_to(363); check("ch0_n5_hi",  32'(clk_out[0]), 32'h1);
    run_to(365); check("ch0_n5_ce",  32'(ce_out[0]),  32'h1);
    run_to(11519); check("ch1_pre",  32'(ce_out[1]),  32'h0);
    run_to(11520); check("ch1_ce",   32'(ce_out[1]),  32'h1);

    // Clamp: 0 then 1 written to ch2 become divisor 2.
    step(0, 1, 2, 0, 0);
    step(0, 1, 2, 1, 0);
    repeat (12) idle();
    check("ch2_n2_pend", 32'(pend[2]), 32'h0);

    // Reset mid-period with a write pending discards the write.
    step(0, 1, 0, 7, 0);
    check("pend_before_rst", 32'(pend[0]), 32'h1);
    step(1, 0, 0, 0, 0);
    check("rst_mid_outs", {pend, ce_out, clk_out}, 32'h0);
    run_to(8);   check("rst_ch2_ce8", 32'(ce_out[2]), 32'h1);

    // Sync at an arbitrary phase, then ch0 and ch2 line up every 360 cycles.
    run_to(50);
    step(0, 0, 0, 0, 1);
    check("sync_outs", {ce_out, clk_out}, 32'h0);
    run_to(360); check("sync_coincide", {30'h0, ce_out[2], ce_out[0]}, 32'h3);

    // Out-of-range select is ignored; write with sync applies immediately.
    step(0, 1, 3, 9, 0);
    check("sel3_ignored", 32'(pend), 32'h0);
    step(0, 1, 1, 10, 1);
    check("wr_sync_pend", 32'(pend), 32'h0);
    run_to(5);   check("ch1_n10_lo", 32'(clk_out[1]), 32'h0);
    run_to(6);   check("ch1_n10_hi", 32'(clk_out[1]), 32'h1);
    run_to(10);  check("ch1_n10_ce", 32'(ce_out[1]),  32'h1);

    // Randomized traffic, mostly short divisors so many wraps occur.
    for (int k = 0; k < 4000; k++) begin
      bit r, w, sy;
      int sel, val;
      r   = ($urandom_range(0, 999) == 0);
      w   = ($urandom_range(0, 7) == 0);
      sy  = ($urandom_range(0, 63) == 0);
      sel = $urandom_range(0, 3);
      val = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 12);
      step(r, w, sel, val, sy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
